// File: rtl/operand_entry.sv
// operand_entry: collects operand A, operand B and an opcode from four
// switches, one value per press of the "next" button, and presents them as
// a registered set for the ALU/display stage.
//
// Build option: define OPERAND_ENTRY_DEBOUNCE_EN to insert a DEB_CYCLES
// stability filter on the synchronized btn_next level. Without it the
// synchronized level is used directly, the counter does not exist and
// DEB_CYCLES has no effect.
//
// Latency from a clean rising edge on btn_next to the latch edge:
//   debounce off : 3 clk edges (2 sync flops + edge-detect)
//   debounce on  : DEB_CYCLES + 3 clk edges
//
// btn_clr (synchronized) dominates everything: while it is high the FSM is
// parked in S_A with cleared operands. Next-press events that arrive while it
// is high are dropped. The edge detector keeps tracking the button level
// during a clear, so releasing btn_clr with the button held cannot generate
// an event on its own.

module operand_entry #(
    parameter int DEB_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clr,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] k,
    output logic [1:0] stage,
    output logic       ready
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [3:0] sw_meta_r;
    logic [3:0] sw_sync_r;
    logic       next_meta_r;
    logic       next_sync_r;
    logic       clr_meta_r;
    logic       clr_sync_r;

    // Two-flop synchronizers for every asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_r   <= 4'h0;
            sw_sync_r   <= 4'h0;
            next_meta_r <= 1'b0;
            next_sync_r <= 1'b0;
            clr_meta_r  <= 1'b0;
            clr_sync_r  <= 1'b0;
        end else begin
            sw_meta_r   <= sw;
            sw_sync_r   <= sw_meta_r;
            next_meta_r <= btn_next;
            next_sync_r <= next_meta_r;
            clr_meta_r  <= btn_clr;
            clr_sync_r  <= clr_meta_r;
        end
    end

    // ------------------------------------------------------------------
    // Conditioned btn_next level
    // ------------------------------------------------------------------
    logic next_level_s;

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    // Counter wide enough to hold DEB_CYCLES-1; never narrower than 1 bit.
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (DEB_CYCLES > 1) ? CNT_W'(DEB_CYCLES - 32'sd1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [CNT_W-1:0] deb_cnt_r;
    logic             next_level_r;

    // Accept a new level only after DEB_CYCLES consecutive differing samples;
    // any matching sample throws the partial count away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_r    <= {CNT_W{1'b0}};
            next_level_r <= 1'b0;
        end else if (next_sync_r == next_level_r) begin
            deb_cnt_r    <= {CNT_W{1'b0}};
            next_level_r <= next_level_r;
        end else if (deb_cnt_r == CNT_LAST) begin
            deb_cnt_r    <= {CNT_W{1'b0}};
            next_level_r <= next_sync_r;
        end else begin
            deb_cnt_r    <= deb_cnt_r + CNT_ONE;
            next_level_r <= next_level_r;
        end
    end

    assign next_level_s = next_level_r;
`else
    // DEB_CYCLES is meaningless without the filter; keep it referenced so
    // the parameter stays part of the interface without a dangling use.
    logic unused_deb_cfg_s;
    assign unused_deb_cfg_s = (DEB_CYCLES > 32'sd0);

    assign next_level_s = next_sync_r;
`endif

    // ------------------------------------------------------------------
    // Rising-edge detector -> one-cycle next-press pulse
    // ------------------------------------------------------------------
    logic next_hist_r;
    logic next_evt_s;

    // Remember the previous conditioned level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_hist_r <= 1'b0;
        end else begin
            next_hist_r <= next_level_s;
        end
    end

    assign next_evt_s = next_level_s & ~next_hist_r;

    // ------------------------------------------------------------------
    // Entry FSM and operand registers
    // ------------------------------------------------------------------
    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] k_r;
    logic [3:0] a_next_s;
    logic [3:0] b_next_s;
    logic [3:0] k_next_s;
    logic       ready_r;
    logic       ready_next_s;

    // Next-state and next-operand logic; clear has priority over a press.
    always_comb begin
        state_next_s = state_r;
        a_next_s     = a_r;
        b_next_s     = b_r;
        k_next_s     = k_r;

        if (clr_sync_r) begin
            state_next_s = S_A;
            a_next_s     = 4'h0;
            b_next_s     = 4'h0;
            k_next_s     = 4'h0;
        end else if (next_evt_s) begin
            case (state_r)
                S_A: begin
                    a_next_s     = sw_sync_r;
                    state_next_s = S_B;
                end
                S_B: begin
                    b_next_s     = sw_sync_r;
                    state_next_s = S_OP;
                end
                S_OP: begin
                    k_next_s     = sw_sync_r;
                    state_next_s = S_SHOW;
                end
                S_SHOW: begin
                    state_next_s = S_A;
                end
                default: begin
                    state_next_s = S_A;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end

        // ready tracks the state being entered, so it drops on the leaving edge.
        ready_next_s = (state_next_s == S_SHOW);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand, opcode and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= 4'h0;
            b_r     <= 4'h0;
            k_r     <= 4'h0;
            ready_r <= 1'b0;
        end else begin
            a_r     <= a_next_s;
            b_r     <= b_next_s;
            k_r     <= k_next_s;
            ready_r <= ready_next_s;
        end
    end

    assign a     = a_r;
    assign b     = b_r;
    assign k     = k_r;
    assign stage = state_r;
    assign ready = ready_r;

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 5000, which is the number of consecutive stable clk cycles needed to accept a button level change.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all flops are on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port sw, input, 4 bits: raw operand/opcode switches, asynchronous to clk.
REQ-005 SHALL have port btn_next, input, 1 bit: raw "enter/advance" pushbutton, active-high, bouncy.
REQ-006 SHALL have port btn_clr, input, 1 bit: raw clear pushbutton, active-high.
REQ-007 SHALL have port a, output, 4 bits: latched operand A for the ALU/display stage.
REQ-008 SHALL have port b, output, 4 bits: latched operand B.
REQ-009 SHALL have port k, output, 4 bits: latched opcode; downstream decodes k[1:0] as 00 zero, 01 add, 10 abs-diff, 11 multiply.
REQ-010 SHALL have port stage, output, 2 bits: current FSM state encoding.
REQ-011 SHALL have port ready, output, 1 bit: high when a, b and k form a complete, consistent set.

Function
REQ-012 SHALL pass sw, btn_next and btn_clr each through a 2-flop synchronizer before any use.
REQ-013 SHALL implement FSM states S_A=00, S_B=01, S_OP=10 and S_SHOW=11, with stage equal to the state code.
REQ-014 SHALL, on a next-press event, make these transitions: S_A latches a<=sw_sync and goes to S_B; S_B latches b<=sw_sync and goes to S_OP; S_OP latches k<=sw_sync and goes to S_SHOW; S_SHOW goes to S_A with a, b and k unchanged.
REQ-015 SHALL hold the state and a, b, k unchanged when no event occurs.
REQ-016 SHALL register ready as (state==S_SHOW) and deassert it on the same edge that leaves S_SHOW.
REQ-017 SHALL make a next-press event a single-cycle pulse on the 0->1 edge of the conditioned btn_next level; holding the button SHALL yield exactly one event.
REQ-018 SHALL, while the synchronized btn_clr is high, force state to S_A, clear a, b and k to 0 and hold ready at 0 on every clk edge.
REQ-019 SHALL give btn_clr priority when it coincides with a next-press event, so no latch occurs.
REQ-020 SHALL discard a next-press event that occurs while btn_clr is high; releasing btn_clr SHALL NOT create an event.
REQ-021 SHALL latch the value of sw_sync sampled on the same clk edge as the event.

Reset
REQ-022 SHALL, while rst_n=0, immediately set state=S_A, a=b=k=0 and ready=0, clear synchronizers, debounce counters and edge-detect history to 0, and hold them there.
REQ-023 SHALL let the first edge after rst_n deasserts act as normal operation; a button already held across reset release SHALL produce one event once the condition in REQ-017 or REQ-025 is met.
REQ-024 SHALL, when reset asserts mid-debounce, discard the partial count.

Configuration
REQ-025 SHALL, with OPERAND_ENTRY_DEBOUNCE_EN defined, update the conditioned btn_next level only after the synchronized input differs from it for DEB_CYCLES consecutive cycles, reset the counter to 0 on any cycle where they match, and fire the event exactly DEB_CYCLES+3 clk edges after a clean rising edge on btn_next.
REQ-026 SHALL, with OPERAND_ENTRY_DEBOUNCE_EN undefined, use the synchronized btn_next directly as the conditioned level, remove the counter logic, ignore DEB_CYCLES, and fire the event 3 clk edges after the rising edge.

Verification
REQ-027 SHALL cover this scenario: DEB_CYCLES=4 with debounce on; press/release with sw=5, then 9, then 3 -> a=5, b=9, k=3, stage=11, ready=1, and each latch occurs 7 edges after its press.
REQ-028 SHALL cover this scenario: debounce on, DEB_CYCLES=4; btn_next toggles every 2 cycles for 20 cycles, then holds high for 10 -> exactly one event, and stage advances by one.
REQ-029 SHALL cover this scenario: in S_SHOW with a=5, b=9, k=3, one press -> stage=00, ready=0, and a, b, k still 5, 9, 3.
REQ-030 SHALL cover this scenario: btn_clr and the next-press event land on the same edge while in S_OP -> stage=00, a=b=k=0, and k is not latched.
REQ-031 SHALL cover this scenario: rst_n pulsed low mid-count while in S_B -> outputs are 0 and stage=00 asynchronously, before the next clk edge.
REQ-032 SHALL cover this scenario: debounce off; press with sw=F -> a=F exactly 3 edges after press, and holding the button 100 cycles yields no second event.
